ternary_mvm_sequencer: RTL and testbench

- Host-side driver for the ternary matrix-vector multiply core.
- Accepts a byte stream of ternary weights and activations over a valid/ready port and holds the 256-bit weight matrix.
- Per inference: sequences the core through InLen/2 row cycles, pulses the result latch, then streams the OutLen result bytes back out with backpressure.

---
 rtl/ternary_mvm_sequencer_pkg.sv | 30 +++
 rtl/ternary_weight_store.sv | 39 +++
 rtl/ternary_mvm_sequencer.sv | 147 ++++++++++++++
 tb/tb_ternary_mvm_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_mvm_sequencer_pkg.sv
// Shared types and default geometry for the ternary MVM sequencer.
// Default sizes give 8 core rows, each driven with two activations and a 32-bit weight row.
package ternary_mvm_sequencer_pkg;

    localparam int IN_LEN    = 16;
    localparam int OUT_LEN   = 8;
    localparam int BIT_WIDTH = 8;

    localparam int R         = IN_LEN / 2;
    localparam int W_BYTES   = 4 * R;
    localparam int W_ROW_W   = 4 * OUT_LEN;
    localparam int ROW_W     = $clog2(R);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    // Each result byte takes three DRAIN steps: present row, capture core output, hold for host.
    typedef enum logic [1:0] {
        DR_SET,
        DR_CAP,
        DR_HOLD
    } drain_ph_t;

endpackage

// File: rtl/ternary_weight_store.sv
// Byte-addressed weight register file with a whole-row combinational read port.
// Write takes effect on the next edge; the read is combinational; no flow control (always accepts).
// Sync reset clears every byte, so weights do not survive a reset.
module ternary_weight_store #(
    parameter int NBytes   = 32,
    parameter int RowBytes = 4,
    parameter int RowW     = 3,
    parameter int AddrW    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [AddrW-1:0]        waddr,
    input  logic [7:0]              wdata,
    input  logic [RowW-1:0]         rd_row,
    output logic [8*RowBytes-1:0]   rd_data
);

    logic [7:0] mem [NBytes];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBytes; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Little-endian: the lowest address of a row lands in rd_data[7:0].
    always_comb begin
        rd_data = '0;
        for (int b = 0; b < RowBytes; b++) begin
            rd_data[8*b +: 8] = mem[AddrW'(int'(rd_row) * RowBytes + b)];
        end
    end

endmodule

// File: rtl/ternary_mvm_sequencer.sv
// Loads weight/activation byte frames, sequences the ternary core row by row, then streams results.
// Core outputs lag state by one cycle: FLUSH strobe R+1 cycles after the last activation, first result 2 cycles later.
// in_ready drops while busy; result bytes hold in res_data until res_ready, stalling the drain.
module ternary_mvm_sequencer
    import ternary_mvm_sequencer_pkg::*;
#(
    parameter int InLen    = IN_LEN,
    parameter int OutLen   = OUT_LEN,
    parameter int BitWidth = BIT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    input  logic                    in_sel,
    output logic                    in_ready,
    output logic                    res_valid,
    output logic [BitWidth-1:0]     res_data,
    input  logic                    res_ready,
    output logic                    busy,
    output logic [ROW_W-1:0]        mvm_row,
    output logic                    mvm_en,
    output logic [2*BitWidth-1:0]   mvm_vec,
    output logic [4*OutLen-1:0]     mvm_w,
    input  logic [BitWidth-1:0]     mvm_res
);

    localparam int NROW   = InLen / 2;
    localparam int RB     = OutLen / 2;
    localparam int WB     = NROW * RB;
    localparam int WA_W   = $clog2(WB);
    localparam int XA_W   = $clog2(InLen);
    localparam int CNT_W  = $clog2((WB > InLen) ? WB : InLen) + 1;

    state_t                 state, state_nxt;
    drain_ph_t              dr_ph;
    logic [CNT_W-1:0]       cnt;
    logic [ROW_W-1:0]       row;
    logic [BitWidth-1:0]    x_buf [InLen];
    logic [4*OutLen-1:0]    w_row;
    logic                   in_fire, res_fire, w_we, x_we, last_w, last_x;

    assign in_ready = !rst && (state == IDLE || state == LOAD_W || state == LOAD_X);
    assign busy     = (state == RUN) || (state == FLUSH) || (state == DRAIN);
    assign in_fire  = in_valid && in_ready;
    assign res_fire = res_valid && res_ready;
    assign last_w   = (cnt == CNT_W'(WB - 1));
    assign last_x   = (cnt == CNT_W'(InLen - 1));
    assign w_we     = in_fire && (state == LOAD_W || (state == IDLE && in_sel));
    assign x_we     = in_fire && (state == LOAD_X || (state == IDLE && !in_sel));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire) state_nxt = in_sel ? LOAD_W : LOAD_X;
            LOAD_W:  if (in_fire && last_w) state_nxt = IDLE;
            LOAD_X:  if (in_fire && last_x) state_nxt = RUN;
            RUN:     if (row == ROW_W'(NROW - 1)) state_nxt = FLUSH;
            FLUSH:   state_nxt = DRAIN;
            DRAIN:   if (dr_ph == DR_HOLD && res_fire && row == ROW_W'(OutLen - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cnt indexes the byte being accepted; row doubles as the RUN row and the DRAIN result index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            row   <= '0;
            dr_ph <= DR_SET;
        end else begin
            if (in_fire) cnt <= (state_nxt == IDLE || state_nxt == RUN) ? '0 : cnt + 1'b1;
            case (state)
                RUN: row <= (state_nxt == RUN) ? row + 1'b1 : '0;
                FLUSH: begin
                    row   <= '0;
                    dr_ph <= DR_SET;
                end
                DRAIN: begin
                    case (dr_ph)
                        DR_SET:  dr_ph <= DR_CAP;
                        DR_CAP:  dr_ph <= DR_HOLD;
                        default: if (res_fire) begin
                            dr_ph <= DR_SET;
                            row   <= (state_nxt == DRAIN) ? row + 1'b1 : '0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < InLen; i++) begin
                x_buf[i] <= '0;
            end
        end else if (x_we) begin
            x_buf[cnt[XA_W-1:0]] <= BitWidth'(in_data);
        end
    end

    ternary_weight_store #(
        .NBytes   (WB),
        .RowBytes (RB),
        .RowW     (ROW_W),
        .AddrW    (WA_W)
    ) u_wstore (
        .clk     (clk),
        .rst     (rst),
        .we      (w_we),
        .waddr   (cnt[WA_W-1:0]),
        .wdata   (in_data),
        .rd_row  (row),
        .rd_data (w_row)
    );

    // Core-facing outputs are registered from the current state, so they trail it by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mvm_row   <= '0;
            mvm_en    <= 1'b0;
            mvm_vec   <= '0;
            mvm_w     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            mvm_row <= (state == RUN || state == DRAIN) ? row : '0;
            mvm_en  <= (state == FLUSH);
            mvm_vec <= (state == RUN) ? {x_buf[XA_W'(2 * int'(row))], x_buf[XA_W'(2 * int'(row) + 1)]} : '0;
            mvm_w   <= (state == RUN) ? w_row : '0;
            if (state == DRAIN && dr_ph == DR_CAP) begin
                res_data  <= mvm_res;
                res_valid <= 1'b1;
            end else if (res_fire) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ternary_mvm_sequencer.sv
// Directed bench for ternary_mvm_sequencer with a behavioural ternary core attached to the mvm_* port.
module tb_ternary_mvm_sequencer;

    logic        clk, rst, in_valid, in_sel, in_ready, res_valid, res_ready, busy, mvm_en;
    logic [7:0]  in_data, res_data, mvm_res;
    logic [2:0]  mvm_row;
    logic [15:0] mvm_vec;
    logic [31:0] mvm_w;

    int total = 0;
    int bad   = 0;

    logic [7:0]  fbuf [32];
    logic [7:0]  got [8];
    logic [2:0]  got_row [8];
    int          n_got;
    bit          stall_ok;
    logic [7:0]  acc [8];
    logic [7:0]  outr [8];

    ternary_mvm_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy),
        .mvm_row   (mvm_row),
        .mvm_en    (mvm_en),
        .mvm_vec   (mvm_vec),
        .mvm_w     (mvm_w),
        .mvm_res   (mvm_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ternary code: 01 = +1, 10 = -1, otherwise 0.
    function automatic logic [7:0] tmul(input logic [7:0] x, input logic [1:0] c);
        if (c == 2'b01) return x;
        if (c == 2'b10) return 8'd0 - x;
        return 8'd0;
    endfunction

    // Core model: accumulates every cycle, latches and clears on mvm_en, result selected by mvm_row.
    always @(posedge clk) begin
        for (int o = 0; o < 8; o++) begin
            if (rst) begin
                acc[o]  <= 8'd0;
                outr[o] <= 8'd0;
            end else if (mvm_en) begin
                outr[o] <= acc[o];
                acc[o]  <= 8'd0;
            end else begin
                acc[o] <= acc[o] + tmul(mvm_vec[15:8], mvm_w[2*o +: 2]) + tmul(mvm_vec[7:0], mvm_w[16 + 2*o +: 2]);
            end
        end
    end

    always_comb mvm_res = outr[mvm_row];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    // Sends fbuf[0..n-1]; in_sel flips on every byte after the first to show it is ignored mid-frame.
    task automatic send_frame(input bit sel, input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            in_valid = 1'b1;
            in_data  = fbuf[i];
            in_sel   = sel ^ i[0];
            t = 0;
            while (!in_ready && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            if (!in_ready) begin
                total++; bad++;
                $display("FAIL send_timeout: byte %0d in_ready=%0b required 1", i, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Collects up to 8 result bytes; optionally withholds res_ready for 5 cycles at index stall_j.
    task automatic collect_results(input int stall_j);
        n_got    = 0;
        stall_ok = 1'b1;
        res_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            int t;
            t = 0;
            while (!res_valid && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (!res_valid) break;
            got[j]     = res_data;
            got_row[j] = mvm_row;
            n_got++;
            if (j == stall_j) begin
                res_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #1;
                    if (res_data !== got[j] || mvm_row !== got_row[j] || res_valid !== 1'b1) stall_ok = 1'b0;
                end
                res_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_sel = 1'b0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready: got %0b required 1", in_ready); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %0b required 0", busy); end
        total++;
        if (res_valid !== 1'b0 || res_data !== 8'd0) begin
            bad++; $display("FAIL idle_res: valid=%0b data=%h required 0/00", res_valid, res_data);
        end
        total++;
        if (mvm_row !== 3'd0 || mvm_en !== 1'b0 || mvm_vec !== 16'd0 || mvm_w !== 32'd0) begin
            bad++; $display("FAIL idle_mvm: row=%0d en=%0b vec=%h w=%h required all zero", mvm_row, mvm_en, mvm_vec, mvm_w);
        end
    endtask

    task automatic test_plus_ones();
        logic [15:0] exp_vec;
        for (int i = 0; i < 32; i++) fbuf[i] = 8'h55;
        send_frame(1'b1, 32);
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL w_frame_end: busy=%0b in_ready=%0b required 0/1", busy, in_ready);
        end
        for (int i = 0; i < 16; i++) fbuf[i] = 8'(i + 1);
        send_frame(1'b0, 16);
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL x_frame_end: busy=%0b in_ready=%0b required 1/0", busy, in_ready);
        end
        for (int r = 0; r < 8; r++) begin
            @(posedge clk); #1;
            exp_vec = {8'(2*r + 1), 8'(2*r + 2)};
            total++;
            if (mvm_row !== 3'(r) || mvm_vec !== exp_vec || mvm_w !== 32'h5555_5555 || mvm_en !== 1'b0) begin
                bad++;
                $display("FAIL run_row%0d: row=%0d vec=%h w=%h en=%0b required %0d/%h/55555555/0", r, mvm_row, mvm_vec, mvm_w, mvm_en, r, exp_vec);
            end
        end
        @(posedge clk); #1;
        total++;
        if (mvm_en !== 1'b1 || mvm_row !== 3'd0 || mvm_vec !== 16'd0 || mvm_w !== 32'd0) begin
            bad++; $display("FAIL flush: en=%0b row=%0d vec=%h w=%h required 1/0/0/0", mvm_en, mvm_row, mvm_vec, mvm_w);
        end
        @(posedge clk); #1;
        total++;
        if (mvm_en !== 1'b0 || res_valid !== 1'b0) begin
            bad++; $display("FAIL flush_plus1: en=%0b res_valid=%0b required 0/0", mvm_en, res_valid);
        end
        @(posedge clk); #1;
        total++;
        if (res_valid !== 1'b1) begin bad++; $display("FAIL first_res_latency: res_valid=%0b required 1", res_valid); end
        collect_results(-1);
        total++;
        if (n_got !== 8) begin bad++; $display("FAIL plus_count: got %0d bytes required 8", n_got); end
        for (int j = 0; j < n_got; j++) begin
            total++;
            if (got[j] !== 8'h88) begin bad++; $display("FAIL plus_res%0d: got %h required 88", j, got[j]); end
        end
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            bad++; $display("FAIL plus_end: busy=%0b res_valid=%0b required 0/0", busy, res_valid);
        end
    endtask

    task automatic test_minus_ones_persist();
        for (int i = 0; i < 32; i++) fbuf[i] = 8'hAA;
        send_frame(1'b1, 32);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++) fbuf[i] = 8'h01;
            send_frame(1'b0, 16);
            collect_results(-1);
            total++;
            if (n_got !== 8) begin bad++; $display("FAIL minus_count pass%0d: got %0d required 8", pass, n_got); end
            for (int j = 0; j < n_got; j++) begin
                total++;
                if (got[j] !== 8'hF0) begin bad++; $display("FAIL minus_res pass%0d idx%0d: got %h required f0", pass, j, got[j]); end
            end
        end
    endtask

    // Row r weights only output r, for both of its activations, so result[o] = x[2o] + x[2o+1].
    task automatic test_drain_stall();
        logic [15:0] half;
        for (int r = 0; r < 8; r++) begin
            half = 16'h0001 << (2*r);
            fbuf[4*r]     = half[7:0];
            fbuf[4*r + 1] = half[15:8];
            fbuf[4*r + 2] = half[7:0];
            fbuf[4*r + 3] = half[15:8];
        end
        send_frame(1'b1, 32);
        for (int i = 0; i < 16; i++) fbuf[i] = 8'(i + 1);
        send_frame(1'b0, 16);
        collect_results(3);
        total++;
        if (n_got !== 8) begin bad++; $display("FAIL stall_count: got %0d required 8", n_got); end
        total++;
        if (stall_ok !== 1'b1) begin bad++; $display("FAIL stall_hold: stable=%0b required 1", stall_ok); end
        for (int j = 0; j < n_got; j++) begin
            total++;
            if (got[j] !== 8'(4*j + 3) || got_row[j] !== 3'(j)) begin
                bad++; $display("FAIL stall_order idx%0d: data=%h row=%0d required %h/%0d", j, got[j], got_row[j], 8'(4*j + 3), j);
            end
        end
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL stall_end: res_valid=%0b busy=%0b required 0/0", res_valid, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 16; i++) fbuf[i] = 8'(i + 1);
        send_frame(1'b0, 16);
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (mvm_row !== 3'd4) begin bad++; $display("FAIL pre_rst_row: got %0d required 4", mvm_row); end
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_run_in_ready: got %0b required 0", in_ready); end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || mvm_row !== 3'd0 || mvm_en !== 1'b0 || mvm_vec !== 16'd0 || mvm_w !== 32'd0) begin
            bad++;
            $display("FAIL rst_run_outputs: busy=%0b rv=%0b row=%0d en=%0b vec=%h w=%h required all zero", busy, res_valid, mvm_row, mvm_en, mvm_vec, mvm_w);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_run_idle: in_ready=%0b required 1", in_ready); end
        @(posedge clk); #1;
        send_frame(1'b0, 16);
        collect_results(-1);
        total++;
        if (n_got !== 8) begin bad++; $display("FAIL cleared_count: got %0d required 8", n_got); end
        for (int j = 0; j < n_got; j++) begin
            total++;
            if (got[j] !== 8'h00) begin bad++; $display("FAIL cleared_res%0d: got %h required 00", j, got[j]); end
        end
    endtask

    task automatic test_input_blocked();
        int t;
        for (int i = 0; i < 16; i++) fbuf[i] = 8'h01;
        send_frame(1'b0, 16);
        in_valid = 1'b1; in_data = 8'h77; in_sel = 1'b1;
        res_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            total++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL blocked_run%0d: in_ready=%0b busy=%0b required 0/1", c, in_ready, busy);
            end
            @(posedge clk); #1;
        end
        t = 0;
        while (!res_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (res_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL blocked_drain: res_valid=%0b in_ready=%0b required 1/0", res_valid, in_ready);
        end
        in_valid = 1'b0;
        collect_results(-1);
        total++;
        if (n_got !== 8) begin bad++; $display("FAIL blocked_count: got %0d required 8", n_got); end
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL blocked_end: busy=%0b in_ready=%0b required 0/1", busy, in_ready);
        end
        send_frame(1'b0, 16);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL x_frame_len: busy=%0b after 16 bytes required 1", busy); end
        collect_results(-1);
        total++;
        if (n_got !== 8) begin bad++; $display("FAIL final_count: got %0d required 8", n_got); end
    endtask

    initial begin
        test_reset();
        test_plus_ones();
        test_minus_ones_persist();
        test_drain_stall();
        test_reset_mid_run();
        test_input_blocked();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
